// File: rtl/product_readout_fifo_if.sv
// Product readout bus: the upstream product strobe and readout command go in.
// The readout byte, flags and occupancy come back out.
interface product_readout_fifo_if;
    logic        prod_valid;
    logic [15:0] prod_in;
    logic [2:0]  comm;
    logic [7:0]  out_8b;
    logic        full;
    logic        empty;
    logic        ovf;
    logic [2:0]  count;

    modport master (
        output prod_valid, prod_in, comm,
        input  out_8b, full, empty, ovf, count
    );

    modport slave (
        input  prod_valid, prod_in, comm,
        output out_8b, full, empty, ovf, count
    );
endinterface

// File: rtl/product_readout_fifo.sv
// Four-entry readout FIFO for 16-bit multiplier products.
// A 3-bit command returns the head one byte at a time, pops the head,
// returns status, clears the overflow flag or flushes the FIFO.
// The byte read and the pop can also happen in the same cycle.
module product_readout_fifo (
    input  logic                   clk,
    input  logic                   rst,
    product_readout_fifo_if.slave  bus
);
    typedef enum logic [2:0] {
        CMD_NOP       = 3'b000,
        CMD_RD_LO     = 3'b001,
        CMD_RD_HI     = 3'b010,
        CMD_POP       = 3'b011,
        CMD_STATUS    = 3'b100,
        CMD_CLR_OVF   = 3'b101,
        CMD_FLUSH     = 3'b110,
        CMD_RD_HI_POP = 3'b111
    } cmd_e;

    logic [15:0] mem [4];
    logic [1:0]  wr_ptr, wr_ptr_d;
    logic [1:0]  rd_ptr, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  out_q, out_d;

    cmd_e        cmd;
    logic        is_full, is_empty;
    logic        flush, pop_do, push_do, push_drop;
    logic [15:0] head;

    assign cmd      = cmd_e'(bus.comm);
    assign is_full  = (count_q == 3'd4);
    assign is_empty = (count_q == 3'd0);
    assign head     = mem[rd_ptr];
    assign flush    = (cmd == CMD_FLUSH);

    // A pop on an empty FIFO is ignored.
    // When the FIFO is full, a pop in the same cycle frees the slot that the push needs.
    assign pop_do    = ((cmd == CMD_POP) || (cmd == CMD_RD_HI_POP)) && !is_empty;
    assign push_do   = bus.prod_valid && !flush && (!is_full || pop_do);
    assign push_drop = bus.prod_valid && !flush && is_full && !pop_do;

    // Next-state decode for pointers, occupancy, overflow flag and readout byte
    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        count_d  = count_q;
        ovf_d    = ovf_q;
        out_d    = out_q;
        if (flush) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            count_d  = 3'd0;
            ovf_d    = 1'b0;
            out_d    = 8'h00;
        end else begin
            if (push_do) wr_ptr_d = wr_ptr + 2'd1;
            if (pop_do)  rd_ptr_d = rd_ptr + 2'd1;
            case ({push_do, pop_do})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
            // A product dropped in the same cycle as CLR_OVF still sets the flag.
            // This way no overflow event is lost.
            if (cmd == CMD_CLR_OVF) ovf_d = 1'b0;
            if (push_drop)          ovf_d = 1'b1;
            // An empty FIFO reads as zero, so unwritten entries never appear on the output.
            case (cmd)
                CMD_RD_LO:                out_d = is_empty ? 8'h00 : head[7:0];
                CMD_RD_HI, CMD_RD_HI_POP: out_d = is_empty ? 8'h00 : head[15:8];
                CMD_STATUS:               out_d = {is_full, is_empty, ovf_q, 2'b00, count_q};
                default:                  out_d = out_q;
            endcase
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count_q <= 3'd0;
            ovf_q   <= 1'b0;
            out_q   <= 8'h00;
        end else begin
            wr_ptr  <= wr_ptr_d;
            rd_ptr  <= rd_ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
        end
    end

    // Storage array has no reset; the occupancy count guards every read of it
    always_ff @(posedge clk) begin
        if (push_do) mem[wr_ptr] <= bus.prod_in;
    end

    assign bus.out_8b = out_q;
    assign bus.count  = count_q;
    assign bus.ovf    = ovf_q;
    assign bus.full   = is_full;
    assign bus.empty  = is_empty;
endmodule

// File: doc/product_readout_fifo.md
PRODUCT_READOUT_FIFO -- requirements
Module: product_readout_fifo

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with the ports named clk and rst as in the rest of the codebase.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 prod_valid  input  1  upstream multiplier product strobe, one push per high cycle.
REQ-005 prod_in  input  16  unsigned approximate product, sampled when prod_valid=1.
REQ-006 comm  input  3  readout command, sampled every rising edge.
REQ-007 out_8b  output  8  registered readout byte.
REQ-008 full  output  1  combinational, count==4.
REQ-009 empty  output  1  combinational, count==0.
REQ-010 ovf  output  1  registered sticky overflow flag.
REQ-011 count  output  3  registered occupancy, range 0..4.

Function
REQ-012 Storage SHALL be 4 entries of 16 bits, organised as a circular buffer with 2-bit wr_ptr/rd_ptr and a 3-bit count.
REQ-013 Push: prod_valid=1 and (count<4 or pop this cycle) -> write prod_in at wr_ptr, wr_ptr+1 mod 4.
REQ-014 Push while full with no pop this cycle SHALL drop the data and set ovf=1; ovf holds until CLR_OVF, FLUSH or rst.
REQ-015 comm decode (one action per cycle, effect visible the cycle after the edge): 000 NOP holds out_8b; 001 RD_LO sets out_8b<=head[7:0]; 010 RD_HI sets out_8b<=head[15:8]; 011 POP drops the head; 100 STATUS sets out_8b<={full,empty,ovf,2'b00,count}; 101 CLR_OVF sets ovf<=0; 110 FLUSH sets pointers and count to 0, ovf to 0 and out_8b to 0; 111 RD_HI_POP sets out_8b<=head[15:8] and pops the head in the same cycle.
REQ-016 head SHALL be mem[rd_ptr] as it is before the edge; RD_LO, RD_HI and RD_HI_POP with count==0 SHALL load out_8b<=8'h00.
REQ-017 POP or RD_HI_POP with count==0 SHALL be ignored: no pointer change and no flag change.
REQ-018 Simultaneous push and pop with 1<=count<=4 SHALL leave count unchanged and advance both pointers; this includes the full case, which SHALL NOT set ovf.
REQ-019 Simultaneous push and pop with count==0 SHALL perform the push only, so count becomes 1.
REQ-020 FLUSH concurrent with a push SHALL discard the push, leaving count=0.
REQ-021 Pointers SHALL wrap from 3 to 0 silently; count SHALL never exceed 4 or go below 0.
REQ-022 STATUS SHALL report the flag and count values as they are before the edge.
REQ-023 Latency: a product pushed at edge N SHALL be readable by RD_LO at edge N+1, with out_8b valid after edge N+1.

Reset
REQ-024 While rst=1, asynchronously: out_8b=8'h00, count=0, wr_ptr=0, rd_ptr=0, ovf=0, so empty=1 and full=0.
REQ-025 Memory contents SHALL NOT be reset, and no output may depend on unwritten entries.
REQ-026 rst asserted mid-operation SHALL discard all pending entries; the first edge after release SHALL be processed normally.

Verification
REQ-027 Reset, push 16'hA5C3, then RD_LO and RD_HI -> out_8b=8'hC3, then 8'hA5; count=1.
REQ-028 Push 5 products 0x0001..0x0005 with no pops -> count=4, full=1, ovf=1; STATUS -> 8'hA4; RD_HI_POP ×4 returns 00 four times with lo bytes 01..04 (RD_LO before each); entry 0x0005 is never seen.
REQ-029 At full, push 0x1234 plus POP in the same cycle -> count stays 4, ovf stays 0, oldest entry removed, 0x1234 read out last.
REQ-030 Empty FIFO, POP then RD_LO -> count=0, out_8b=8'h00; STATUS -> 8'h40.
REQ-031 Wrap: push/pop 10 products one at a time -> each read matches the value pushed, pointers wrap past 3 with no corruption.
REQ-032 rst pulse with count=3 and ovf=1, then CLR_OVF and FLUSH after release as no-ops -> STATUS=8'h40, and a subsequent push reads back correctly.
